arp_resolver: RTL and testbench

Parametrised ARP resolver between the ARP RX/TX engine (`arp`) and the UDP/IP transmit path, clocked in the GMII domain. It holds an N-entry IP→MAC cache that learns from every received ARP packet, answers IP lookups, and issues broadcast ARP requests with timed retries on a miss. It also schedules ARP replies to incoming requests. The fixed single-peer `des_mac`/`des_ip` loopback is replaced by this block.

---
 rtl/arp_pkg.sv | 31 +++
 rtl/arp_cache_table.sv | 110 +++++++++++
 rtl/arp_resolver.sv | 192 +++++++++++++++++++
 tb/tb_arp_resolver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared definitions for the ARP resolver: opcodes, broadcast address,
// resolver FSM states and the cache entry layout.
package arp_pkg;

    localparam logic        ARP_OP_REQ   = 1'b0;
    localparam logic        ARP_OP_REPLY = 1'b1;
    localparam logic [47:0] BCAST_MAC    = 48'hffff_ffff_ffff;

    // Storage width of the age field; the table only counts within
    // clog2(AGE_MAX+1) bits of it, so AGE_MAX must stay below 2**16.
    localparam int AGE_FIELD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_TX_REQ,
        ST_WAIT_TX,
        ST_WAIT_RESP,
        ST_TX_REPLY,
        ST_WAIT_RPL,
        ST_DONE
    } arp_state_e;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            ip;
        logic [47:0]            mac;
        logic [AGE_FIELD_W-1:0] age;
    } arp_entry_t;

endpackage

// File: rtl/arp_cache_table.sv
// IP->MAC cache: learns from every received ARP packet, ages entries on
// age_tick and compares a lookup IP against all entries in parallel.
module arp_cache_table
    import arp_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int AGE_MAX = 300
) (
    input  logic        gmii_clk,
    input  logic        sys_rst_n,
    input  logic        cache_clr,
    input  logic        learn_en,
    input  logic [31:0] learn_ip,
    input  logic [47:0] learn_mac,
    input  logic        age_tick,
    input  logic [31:0] cmp_ip,
    output logic        hit,
    output logic [47:0] hit_mac,
    output logic        learn_match
);

    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam int IDX_W = $clog2(ENTRIES);

    arp_entry_t tbl_q [ENTRIES];
    arp_entry_t tbl_d [ENTRIES];

    logic [IDX_W-1:0]       victim;
    logic [IDX_W-1:0]       match_idx;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       oldest_idx;
    logic [AGE_FIELD_W-1:0] oldest_age;
    logic                   match_found;
    logic                   free_found;
    logic [AGE_W-1:0]       age_inc;

    // Victim: existing entry for this IP, else lowest free slot, else the
    // oldest entry (strict compare keeps ties on the lowest index).
    always_comb begin
        match_idx   = '0;
        free_idx    = '0;
        oldest_idx  = '0;
        oldest_age  = tbl_q[0].age;
        match_found = 1'b0;
        free_found  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!match_found && tbl_q[i].valid && tbl_q[i].ip == learn_ip) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!free_found && !tbl_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (tbl_q[i].age > oldest_age) begin
                oldest_age = tbl_q[i].age;
                oldest_idx = IDX_W'(i);
            end
        end
        victim = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
    end

    // Later assignments win: aging, then learn, then clear.
    always_comb begin
        age_inc = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            tbl_d[i] = tbl_q[i];
            if (age_tick && tbl_q[i].valid) begin
                age_inc         = AGE_W'(tbl_q[i].age) + AGE_W'(1);
                tbl_d[i].age    = AGE_FIELD_W'(age_inc);
                if (age_inc == AGE_W'(AGE_MAX)) begin
                    tbl_d[i].valid = 1'b0;
                end
            end
            if (learn_en && victim == IDX_W'(i)) begin
                tbl_d[i] = '{valid: 1'b1, ip: learn_ip, mac: learn_mac, age: '0};
            end
            if (cache_clr) begin
                tbl_d[i].valid = 1'b0;
                tbl_d[i].age   = '0;
            end
        end
    end

    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_mac = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && tbl_q[i].valid && tbl_q[i].ip == cmp_ip) begin
                hit     = 1'b1;
                hit_mac = tbl_q[i].mac;
            end
        end
    end

    assign learn_match = learn_en && (learn_ip == cmp_ip);

endmodule

// File: rtl/arp_resolver.sv
// ARP resolver: cache lookups with broadcast requests and timed retries on a
// miss, plus scheduling of replies to received ARP requests.
module arp_resolver
    import arp_pkg::*;
#(
    parameter int ENTRIES    = 4,
    parameter int AGE_MAX    = 300,
    parameter int RETRY_MAX  = 3,
    parameter int RETRY_WAIT = 125000
) (
    input  logic        gmii_clk,
    input  logic        sys_rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        age_tick,
    input  logic        cache_clr,
    input  logic        lookup_req,
    input  logic [31:0] lookup_ip,
    output logic        lookup_ack,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac,
    output logic        busy,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        tx_done
);

    localparam int RETRY_W = $clog2(RETRY_MAX + 1);
    localparam int WAIT_W  = $clog2(RETRY_WAIT + 1);

    arp_state_e         state_q, state_d;
    logic [31:0]        req_ip_q, req_ip_d;
    logic               reply_pend_q, reply_pend_d;
    logic [47:0]        rpl_mac_q, rpl_mac_d;
    logic [31:0]        rpl_ip_q, rpl_ip_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               lookup_hit_q, lookup_hit_d;
    logic [47:0]        lookup_mac_q, lookup_mac_d;
    logic [47:0]        des_mac_q, des_mac_d;
    logic [31:0]        des_ip_q, des_ip_d;

    logic               tbl_hit;
    logic [47:0]        tbl_hit_mac;
    logic               learn_match;
    logic [RETRY_W-1:0] retry_inc;

    arp_cache_table #(
        .ENTRIES (ENTRIES),
        .AGE_MAX (AGE_MAX)
    ) u_table (
        .gmii_clk    (gmii_clk),
        .sys_rst_n   (sys_rst_n),
        .cache_clr   (cache_clr),
        .learn_en    (arp_rx_done),
        .learn_ip    (src_ip),
        .learn_mac   (src_mac),
        .age_tick    (age_tick),
        .cmp_ip      (req_ip_q),
        .hit         (tbl_hit),
        .hit_mac     (tbl_hit_mac),
        .learn_match (learn_match)
    );

    assign retry_inc = retry_cnt_q + RETRY_W'(1);

    always_comb begin
        state_d      = state_q;
        req_ip_d     = req_ip_q;
        reply_pend_d = reply_pend_q;
        rpl_mac_d    = rpl_mac_q;
        rpl_ip_d     = rpl_ip_q;
        retry_cnt_d  = retry_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        lookup_hit_d = lookup_hit_q;
        lookup_mac_d = lookup_mac_q;
        des_mac_d    = des_mac_q;
        des_ip_d     = des_ip_q;

        case (state_q)
            ST_IDLE: begin
                if (reply_pend_q) begin
                    des_mac_d    = rpl_mac_q;
                    des_ip_d     = rpl_ip_q;
                    reply_pend_d = 1'b0;
                    state_d      = ST_TX_REPLY;
                end else if (lookup_req) begin
                    req_ip_d = lookup_ip;
                    state_d  = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (tbl_hit) begin
                    lookup_hit_d = 1'b1;
                    lookup_mac_d = tbl_hit_mac;
                    state_d      = ST_DONE;
                end else begin
                    retry_cnt_d = '0;
                    des_mac_d   = BCAST_MAC;
                    des_ip_d    = req_ip_q;
                    state_d     = ST_TX_REQ;
                end
            end
            ST_TX_REQ: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (tx_done) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT_RESP;
                end
            end
            // The answering packet's MAC is taken straight off the bus; the
            // table write of the same packet lands on this edge too.
            ST_WAIT_RESP: begin
                if (learn_match) begin
                    lookup_hit_d = 1'b1;
                    lookup_mac_d = src_mac;
                    state_d      = ST_DONE;
                end else if (wait_cnt_q == WAIT_W'(RETRY_WAIT - 1)) begin
                    retry_cnt_d = retry_inc;
                    if (retry_inc == RETRY_W'(RETRY_MAX)) begin
                        lookup_hit_d = 1'b0;
                        lookup_mac_d = '0;
                        state_d      = ST_DONE;
                    end else begin
                        des_mac_d = BCAST_MAC;
                        des_ip_d  = req_ip_q;
                        state_d   = ST_TX_REQ;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_TX_REPLY: state_d = ST_WAIT_RPL;
            ST_WAIT_RPL: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A request landing while a reply is being launched stays pending.
        if (arp_rx_done && arp_rx_type == ARP_OP_REQ) begin
            reply_pend_d = 1'b1;
            rpl_mac_d    = src_mac;
            rpl_ip_d     = src_ip;
        end
    end

    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            req_ip_q     <= '0;
            reply_pend_q <= 1'b0;
            rpl_mac_q    <= '0;
            rpl_ip_q     <= '0;
            retry_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            lookup_hit_q <= 1'b0;
            lookup_mac_q <= '0;
            des_mac_q    <= BCAST_MAC;
            des_ip_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_ip_q     <= req_ip_d;
            reply_pend_q <= reply_pend_d;
            rpl_mac_q    <= rpl_mac_d;
            rpl_ip_q     <= rpl_ip_d;
            retry_cnt_q  <= retry_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            lookup_hit_q <= lookup_hit_d;
            lookup_mac_q <= lookup_mac_d;
            des_mac_q    <= des_mac_d;
            des_ip_q     <= des_ip_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign arp_tx_en   = (state_q == ST_TX_REQ) || (state_q == ST_TX_REPLY);
    assign arp_tx_type = (state_q == ST_TX_REPLY) ? ARP_OP_REPLY : ARP_OP_REQ;
    assign lookup_ack  = (state_q == ST_DONE);
    assign lookup_hit  = lookup_hit_q;
    assign lookup_mac  = lookup_mac_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: hit, resolved miss with reply scheduling,
// eviction + retry timeout, aging, and reset in the middle of a request.
module tb_arp_resolver;

    localparam int RETRY_WAIT = 100;
    localparam int AGE_MAX    = 300;

    localparam logic [47:0] BCAST    = 48'hffff_ffff_ffff;
    localparam logic [31:0] IP_HIT   = 32'hc0a8_0166;
    localparam logic [47:0] MAC_HIT  = 48'h0011_2233_4455;
    localparam logic [31:0] IP_MISS  = 32'hc0a8_0132;
    localparam logic [47:0] MAC_MISS = 48'haabb_ccdd_ee01;
    localparam logic [31:0] IP_REQ   = 32'hc0a8_0107;
    localparam logic [47:0] MAC_REQ  = 48'h0200_0000_0007;
    localparam logic [31:0] IP_A     = 32'h0a00_0001;
    localparam logic [31:0] IP_B     = 32'h0a00_0002;
    localparam logic [31:0] IP_C     = 32'h0a00_0003;
    localparam logic [31:0] IP_D     = 32'h0a00_0004;
    localparam logic [31:0] IP_E     = 32'h0a00_0005;
    localparam logic [31:0] IP_F     = 32'h0a00_0009;
    localparam logic [47:0] MAC_A    = 48'h0200_0000_00a1;
    localparam logic [47:0] MAC_B    = 48'h0200_0000_00a2;
    localparam logic [47:0] MAC_C    = 48'h0200_0000_00a3;
    localparam logic [47:0] MAC_D    = 48'h0200_0000_00a4;
    localparam logic [47:0] MAC_E    = 48'h0200_0000_00a5;
    localparam logic [47:0] MAC_F    = 48'h0200_0000_00a9;

    logic        gmii_clk;
    logic        sys_rst_n;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        age_tick;
    logic        cache_clr;
    logic        lookup_req;
    logic [31:0] lookup_ip;
    logic        lookup_ack;
    logic        lookup_hit;
    logic [47:0] lookup_mac;
    logic        busy;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        tx_done;

    int cmpCount  = 0;
    int failCount = 0;
    int reqCount  = 0;
    int extraTx   = 0;

    arp_resolver #(
        .ENTRIES    (4),
        .AGE_MAX    (AGE_MAX),
        .RETRY_MAX  (3),
        .RETRY_WAIT (RETRY_WAIT)
    ) dut (
        .gmii_clk    (gmii_clk),
        .sys_rst_n   (sys_rst_n),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .age_tick    (age_tick),
        .cache_clr   (cache_clr),
        .lookup_req  (lookup_req),
        .lookup_ip   (lookup_ip),
        .lookup_ack  (lookup_ack),
        .lookup_hit  (lookup_hit),
        .lookup_mac  (lookup_mac),
        .busy        (busy),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .tx_done     (tx_done)
    );

    initial gmii_clk = 1'b0;
    always #4 gmii_clk = ~gmii_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge gmii_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rxType, input logic [47:0] mac,
                                 input logic [31:0] ip);
        arp_rx_done = 1'b1;
        arp_rx_type = rxType;
        src_mac     = mac;
        src_ip      = ip;
        step();
        arp_rx_done = 1'b0;
    endtask

    task automatic startLookup(input logic [31:0] ip);
        lookup_req = 1'b1;
        lookup_ip  = ip;
        step();
        lookup_req = 1'b0;
    endtask

    task automatic pulseTxDone();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic pulseAgeTick(input int count);
        age_tick = 1'b1;
        repeat (count) step();
        age_tick = 1'b0;
    endtask

    task automatic waitTxEn(input int budget, input string tag);
        int n = 0;
        while (arp_tx_en !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, {63'd0, arp_tx_en}, 64'd1);
    endtask

    task automatic waitAck(input int budget, input string tag, output int txSeen);
        int n = 0;
        txSeen = 0;
        while (lookup_ack !== 1'b1 && n < budget) begin
            if (arp_tx_en === 1'b1) txSeen++;
            step();
            n++;
        end
        checkOutput(tag, {63'd0, lookup_ack}, 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ack"},     {63'd0, lookup_ack},  64'd0);
        checkOutput({tag, "_hit"},     {63'd0, lookup_hit},  64'd0);
        checkOutput({tag, "_mac"},     {16'd0, lookup_mac},  64'd0);
        checkOutput({tag, "_busy"},    {63'd0, busy},        64'd0);
        checkOutput({tag, "_tx_en"},   {63'd0, arp_tx_en},   64'd0);
        checkOutput({tag, "_tx_type"}, {63'd0, arp_tx_type}, 64'd0);
        checkOutput({tag, "_des_mac"}, {16'd0, des_mac},     {16'd0, BCAST});
        checkOutput({tag, "_des_ip"},  {32'd0, des_ip},      64'd0);
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        src_mac     = '0;
        src_ip      = '0;
        age_tick    = 1'b0;
        cache_clr   = 1'b0;
        lookup_req  = 1'b0;
        lookup_ip   = '0;
        tx_done     = 1'b0;

        #20;
        checkResetOutputs("reset");
        step();
        sys_rst_n = 1'b1;
        step();

        $display("[TB] cache hit");
        applyStimulus(1'b1, MAC_HIT, IP_HIT);
        startLookup(IP_HIT);
        checkOutput("hit_search_busy", {63'd0, busy}, 64'd1);
        checkOutput("hit_search_ack", {63'd0, lookup_ack}, 64'd0);
        step();
        checkOutput("hit_ack", {63'd0, lookup_ack}, 64'd1);
        checkOutput("hit_flag", {63'd0, lookup_hit}, 64'd1);
        checkOutput("hit_mac", {16'd0, lookup_mac}, {16'd0, MAC_HIT});
        checkOutput("hit_no_tx", {63'd0, arp_tx_en}, 64'd0);
        step();
        checkOutput("hit_idle", {63'd0, busy}, 64'd0);

        $display("[TB] miss resolved on second attempt, request queued meanwhile");
        startLookup(IP_MISS);
        step();
        checkOutput("miss_tx_en", {63'd0, arp_tx_en}, 64'd1);
        checkOutput("miss_tx_type", {63'd0, arp_tx_type}, 64'd0);
        checkOutput("miss_des_mac", {16'd0, des_mac}, {16'd0, BCAST});
        checkOutput("miss_des_ip", {32'd0, des_ip}, {32'd0, IP_MISS});
        step();
        pulseTxDone();
        applyStimulus(1'b0, MAC_REQ, IP_REQ);
        waitTxEn(2 * RETRY_WAIT, "miss_second_req");
        checkOutput("miss2_tx_type", {63'd0, arp_tx_type}, 64'd0);
        checkOutput("miss2_des_mac", {16'd0, des_mac}, {16'd0, BCAST});
        checkOutput("miss2_des_ip", {32'd0, des_ip}, {32'd0, IP_MISS});
        step();
        pulseTxDone();
        applyStimulus(1'b1, MAC_MISS, IP_MISS);
        checkOutput("resolved_ack", {63'd0, lookup_ack}, 64'd1);
        checkOutput("resolved_hit", {63'd0, lookup_hit}, 64'd1);
        checkOutput("resolved_mac", {16'd0, lookup_mac}, {16'd0, MAC_MISS});
        waitTxEn(4, "reply_tx_en");
        checkOutput("reply_tx_type", {63'd0, arp_tx_type}, 64'd1);
        checkOutput("reply_des_ip", {32'd0, des_ip}, {32'd0, IP_REQ});
        checkOutput("reply_des_mac", {16'd0, des_mac}, {16'd0, MAC_REQ});
        step();
        pulseTxDone();
        checkOutput("reply_idle", {63'd0, busy}, 64'd0);

        $display("[TB] replacement of the oldest entry and retry timeout");
        cache_clr = 1'b1;
        step();
        cache_clr = 1'b0;
        applyStimulus(1'b1, MAC_A, IP_A);
        applyStimulus(1'b1, MAC_B, IP_B);
        applyStimulus(1'b1, MAC_C, IP_C);
        applyStimulus(1'b1, MAC_D, IP_D);
        pulseAgeTick(1);
        applyStimulus(1'b1, MAC_A, IP_A);
        applyStimulus(1'b1, MAC_B, IP_B);
        applyStimulus(1'b1, MAC_D, IP_D);
        applyStimulus(1'b1, MAC_E, IP_E);
        startLookup(IP_E);
        step();
        checkOutput("new_entry_hit", {63'd0, lookup_hit}, 64'd1);
        checkOutput("new_entry_mac", {16'd0, lookup_mac}, {16'd0, MAC_E});
        step();
        startLookup(IP_A);
        step();
        checkOutput("kept_entry_mac", {16'd0, lookup_mac}, {16'd0, MAC_A});
        step();
        startLookup(IP_C);
        step();
        checkOutput("evicted_miss", {63'd0, arp_tx_en}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) waitTxEn(2 * RETRY_WAIT, "timeout_req");
            if (arp_tx_en === 1'b1) reqCount++;
            checkOutput("timeout_des_ip", {32'd0, des_ip}, {32'd0, IP_C});
            step();
            pulseTxDone();
        end
        waitAck(2 * RETRY_WAIT, "timeout_ack", extraTx);
        checkOutput("timeout_hit", {63'd0, lookup_hit}, 64'd0);
        checkOutput("timeout_extra_tx", 64'(extraTx), 64'd0);
        checkOutput("timeout_req_count", 64'(reqCount), 64'd3);
        step();

        $display("[TB] aging");
        pulseAgeTick(AGE_MAX - 1);
        startLookup(IP_A);
        step();
        checkOutput("age_below_max_hit", {63'd0, lookup_hit}, 64'd1);
        checkOutput("age_below_max_ack", {63'd0, lookup_ack}, 64'd1);
        step();
        pulseAgeTick(1);
        applyStimulus(1'b1, MAC_F, IP_F);
        startLookup(IP_A);
        step();
        checkOutput("aged_out_miss", {63'd0, arp_tx_en}, 64'd1);
        step();
        checkOutput("wait_tx_busy", {63'd0, busy}, 64'd1);

        $display("[TB] reset while waiting for tx_done");
        sys_rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        step();
        step();
        sys_rst_n = 1'b1;
        step();
        startLookup(IP_F);
        step();
        checkOutput("flushed_miss", {63'd0, arp_tx_en}, 64'd1);
        checkOutput("flushed_no_ack", {63'd0, lookup_ack}, 64'd0);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
